// File: rtl/voting_round_ctrl.sv
// Election round controller: round-robin ballot collection, yes/no tally and majority/tie-break decision.
// Optional macro VOTE_TIMEOUT_EN closes the round after TIMEOUT_CYC cycles in COLLECT.
module voting_round_ctrl #(
  parameter int NUM_VOTERS  = 7,
  parameter int CNT_W       = $clog2(NUM_VOTERS + 1),
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  close,
  input  logic                  tie_break,
  input  logic [NUM_VOTERS-1:0] req,
  input  logic [NUM_VOTERS-1:0] ballot,
  output logic [NUM_VOTERS-1:0] gnt,
  output logic [NUM_VOTERS-1:0] voted_mask,
  output logic [CNT_W-1:0]      yes_cnt,
  output logic [CNT_W-1:0]      no_cnt,
  output logic                  busy,
  output logic                  result,
  output logic                  result_valid,
  output logic                  timed_out
);

  localparam int PTR_W = $clog2(NUM_VOTERS);

  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, DONE} state_t;

  state_t                  state_reg;
  logic [PTR_W-1:0]        ptr_reg;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W-1:0]        ptr_next;
  logic [PTR_W:0]          scan_sum;
  logic [PTR_W-1:0]        scan_idx;
  logic [NUM_VOTERS-1:0]   eligible;
  logic                    gnt_any;
  logic                    ballot_yes;
  logic                    all_voted;
  logic                    tmo_hit;
  logic                    close_hit;
  logic                    round_open;

  // Scan from the pointer, wrapping, and take the first eligible voter.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    eligible = req & ~voted_mask;
    if (state_reg == COLLECT) begin
      for (int k = 0; k < NUM_VOTERS; k++) begin
        scan_sum = {1'b0, ptr_reg} + (PTR_W + 1)'(k);
        if (int'(scan_sum) >= NUM_VOTERS)
          scan_sum = scan_sum - (PTR_W + 1)'(NUM_VOTERS);
        scan_idx = scan_sum[PTR_W-1:0];
        if (!gnt_any && eligible[scan_idx]) begin
          gnt[scan_idx] = 1'b1;
          gnt_any       = 1'b1;
          gnt_idx       = scan_idx;
        end
      end
    end
  end

  assign ptr_next   = (gnt_idx == PTR_W'(NUM_VOTERS - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign ballot_yes = |(gnt & ballot);
  assign all_voted  = &(voted_mask | gnt);
  assign close_hit  = close | tmo_hit;
  assign round_open = ((state_reg == IDLE) || (state_reg == DONE)) && start;

`ifdef VOTE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_reg;

  assign tmo_hit = (state_reg == COLLECT) && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
      timed_out   <= 1'b0;
    end else if (round_open) begin
      tmo_cnt_reg <= '0;
      timed_out   <= 1'b0;
    end else if (state_reg == COLLECT) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      if (tmo_hit)
        timed_out <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign timed_out  = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      voted_mask   <= '0;
      yes_cnt      <= '0;
      no_cnt       <= '0;
      busy         <= 1'b0;
      result       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= COLLECT;
            voted_mask   <= '0;
            yes_cnt      <= '0;
            no_cnt       <= '0;
            busy         <= 1'b1;
            result       <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        COLLECT: begin
          // A ballot granted in the closing cycle still counts.
          if (gnt_any) begin
            voted_mask <= voted_mask | gnt;
            ptr_reg    <= ptr_next;
            if (ballot_yes)
              yes_cnt <= yes_cnt + CNT_W'(1);
            else
              no_cnt  <= no_cnt + CNT_W'(1);
          end
          if (all_voted || close_hit)
            state_reg <= DECIDE;
        end
        DECIDE: begin
          result       <= (yes_cnt > no_cnt) | ((yes_cnt == no_cnt) & tie_break);
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state_reg    <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voting_round_ctrl.sv
// Scoreboard bench for voting_round_ctrl: expected grants and round results are queued
// as stimulus is applied and compared as the controller produces them.
module tb_voting_round_ctrl;

  localparam int N  = 7;
  localparam int CW = 3;
`ifdef VOTE_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          close;
  logic          tie_break;
  logic [N-1:0]  req;
  logic [N-1:0]  ballot;
  logic [N-1:0]  gnt;
  logic [N-1:0]  voted_mask;
  logic [CW-1:0] yes_cnt;
  logic [CW-1:0] no_cnt;
  logic          busy;
  logic          result;
  logic          result_valid;
  logic          timed_out;

  voting_round_ctrl #(
    .NUM_VOTERS (N),
    .CNT_W      (CW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .close       (close),
    .tie_break   (tie_break),
    .req         (req),
    .ballot      (ballot),
    .gnt         (gnt),
    .voted_mask  (voted_mask),
    .yes_cnt     (yes_cnt),
    .no_cnt      (no_cnt),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .timed_out   (timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   yes;
    int   no;
    logic res;
    logic tmo;
  } res_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   gnt_q[$];
  res_t res_q[$];
  logic rv_prev  = 1'b0;
  int   m_ptr    = 0;
  int   n_cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_grant(input int i);
    gnt_q.push_back(i);
    m_ptr = (i + 1) % N;
  endtask

  // Voters requesting together are served in rotation starting at the pointer.
  task automatic push_order(input logic [N-1:0] m);
    int base;
    int idx;
    base = m_ptr;
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (m[idx]) push_grant(idx);
    end
  endtask

  task automatic push_result(input int y, input int n, input logic r, input logic t);
    res_t e;
    e.yes = y; e.no = n; e.res = r; e.tmo = t;
    res_q.push_back(e);
  endtask

  task automatic step();
    logic [N-1:0] g;
    int           e;
    res_t         er;
    @(negedge clk);
    g = gnt;
    if (g != '0) begin
      check_eq("gnt_onehot", 32'($onehot(g)), 32'd1);
      if (gnt_q.size() == 0) begin
        check_eq("gnt_unexpected", 32'(g), 32'd0);
      end else begin
        e = gnt_q.pop_front();
        check_eq("gnt_order", 32'(g), 32'd1 << e);
        $display("txn grant mask=%b expected_voter=%0d ballot=%0d", g, e, |(g & ballot));
      end
    end
    @(posedge clk);
    #1;
    req   = req & ~g;
    start = 1'b0;
    close = 1'b0;
    if (result_valid && !rv_prev) begin
      if (res_q.size() == 0) begin
        check_eq("result_unexpected", 32'(result_valid), 32'd0);
      end else begin
        er = res_q.pop_front();
        check_eq("yes_cnt", 32'(yes_cnt), 32'(er.yes));
        check_eq("no_cnt", 32'(no_cnt), 32'(er.no));
        check_eq("result", 32'(result), 32'(er.res));
        check_eq("timed_out", 32'(timed_out), 32'(er.tmo));
        $display("txn result yes=%0d no=%0d result=%0d timed_out=%0d", yes_cnt, no_cnt, result, timed_out);
      end
    end
    rv_prev = result_valid;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!result_valid && n < max) begin
      step();
      n++;
    end
    if (!result_valid) check_eq("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, "_mask"}, 32'(voted_mask), 32'd0);
    check_eq({tag, "_yes"}, 32'(yes_cnt), 32'd0);
    check_eq({tag, "_no"}, 32'(no_cnt), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_result"}, 32'(result), 32'd0);
    check_eq({tag, "_rv"}, 32'(result_valid), 32'd0);
    check_eq({tag, "_tmo"}, 32'(timed_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; close = 1'b0; tie_break = 1'b0;
    req = '1; ballot = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    req = '0;
    rst_n = 1'b1;

    // Round 1: everyone requests at once
    ballot = 7'b1001011;
    req    = '1;
    push_order(7'b1111111);
    push_result(4, 3, 1'b1, 1'b0);
    start = 1'b1;
    step();
    check_eq("busy_collect", 32'(busy), 32'd1);
    repeat (7) step();
    check_eq("mask_full", 32'(voted_mask), 32'h7f);
    check_eq("rv_decide", 32'(result_valid), 32'd0);
    check_eq("busy_decide", 32'(busy), 32'd1);
    step();
    check_eq("rv_latency", 32'(result_valid), 32'd1);
    check_eq("busy_done", 32'(busy), 32'd0);
    step();
    check_eq("done_hold", 32'(result), 32'd1);

    // Round 2: move pointer to 5, then voters 2 and 6 compete
    ballot = 7'b1010000;
    req    = 7'b0010000;
    push_grant(4);
    start = 1'b1;
    step();
    step();
    req = req | 7'b1000100;
    push_grant(6);
    push_grant(2);
    step();
    step();
    req[6] = 1'b1;
    start  = 1'b1;
    step();
    step();
    step();
    check_eq("start_in_collect", 32'(voted_mask), 32'b1010100);
    req   = '0;
    close = 1'b1;
    push_result(2, 1, 1'b1, 1'b0);
    step();
    wait_done(20, n_cyc);
    step();

    // Rounds 3 and 4: tie decided by tie_break
    for (int tb_val = 0; tb_val < 2; tb_val++) begin
      tie_break = tb_val[0];
      ballot    = 7'b0000111;
      req       = 7'b0111111;
      push_order(7'b0111111);
      push_result(3, 3, tb_val[0], 1'b0);
      start = 1'b1;
      step();
      repeat (6) step();
      close = 1'b1;
      step();
      wait_done(20, n_cyc);
      step();
    end

    // Round 5: close coincides with a yes grant
    tie_break = 1'b1;
    ballot    = 7'b0010000;
    req       = 7'b0011000;
    push_order(7'b0011000);
    push_result(1, 1, 1'b1, 1'b0);
    start = 1'b1;
    step();
    step();
    close = 1'b1;
    step();
    wait_done(20, n_cyc);
    step();

    // Round 6: no ballots at all yields tie_break
    tie_break = 1'b1;
    push_result(0, 0, 1'b1, 1'b0);
    start = 1'b1;
    step();
    close = 1'b1;
    step();
    wait_done(20, n_cyc);
    step();

    // Round 7: reset after three ballots, then an all-no round
    ballot = '1;
    req    = '1;
    push_grant(5);
    push_grant(6);
    push_grant(0);
    start = 1'b1;
    step();
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    req = '0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rv_prev = 1'b0;
    m_ptr   = 0;
    tie_break = 1'b0;
    ballot = '0;
    req    = '1;
    push_order(7'b1111111);
    push_result(0, 7, 1'b0, 1'b0);
    start = 1'b1;
    step();
    wait_done(20, n_cyc);
    step();

`ifdef VOTE_TIMEOUT_EN
    // Round 8: only two voters show up, round ends by timeout
    ballot = 7'b0000011;
    req    = 7'b0000011;
    push_order(7'b0000011);
    push_result(2, 0, 1'b1, 1'b1);
    start = 1'b1;
    step();
    wait_done(40, n_cyc);
    check_eq("timeout_cycles", 32'(n_cyc), 32'd9);
    step();
`endif

    check_eq("gnt_queue_left", 32'(gnt_q.size()), 32'd0);
    check_eq("res_queue_left", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voting_round_ctrl.md
# voting_round_ctrl

Sequential controller that runs one election round for the voting comparator datapath. It collects one ballot per voter from NUM_VOTERS requesters through a round-robin arbiter, tallies yes/no counts, and applies the majority-with-tie-break decision. The decision is the same function the combinational voting netlist computes in one shot. The block sits between voter front-ends and the result consumer and owns round open/close sequencing.

## Interface
- NUM_VOTERS, 7, number of voter requesters (2..32)
- CNT_W, $clog2(NUM_VOTERS+1), tally counter width
- TIMEOUT_CYC, 255, COLLECT-state cycle limit (used only with VOTE_TIMEOUT_EN)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  open a new round (pulse); honoured only in IDLE or DONE
- close  in  1  force round closed; honoured only in COLLECT
- tie_break  in  1  decision value when yes_cnt == no_cnt; sampled in DECIDE
- req  in  NUM_VOTERS  per-voter ballot request, held until granted
- ballot  in  NUM_VOTERS  per-voter vote (1 = yes); must be stable while req is high
- gnt  out  NUM_VOTERS  one-hot combinational grant; ballot consumed at the edge where req&gnt
- voted_mask  out  NUM_VOTERS  registered; bit i set once voter i's ballot is accepted
- yes_cnt, no_cnt  out  CNT_W  registered tallies
- busy  out  1  high in COLLECT and DECIDE
- result  out  1  registered decision
- result_valid  out  1  high throughout DONE
- timed_out  out  1  round closed by timeout (VOTE_TIMEOUT_EN only; tied 0 otherwise)

## Operation
- States: IDLE, COLLECT, DECIDE, DONE.
- Reset values: state IDLE; gnt, voted_mask, yes_cnt, no_cnt, result, result_valid, timed_out, busy all 0; round-robin pointer 0.
- IDLE/DONE + start: go to COLLECT. Clear voted_mask, counts, result, result_valid, timed_out.
- COLLECT grant: eligible = req & ~voted_mask. gnt is the first eligible bit at or after the pointer, wrapping modulo NUM_VOTERS. At most one grant per cycle; no grant when eligible is 0.
- On a grant to voter i: set voted_mask[i]; increment yes_cnt if ballot[i] is 1, otherwise increment no_cnt; pointer becomes (i+1) mod NUM_VOTERS.
- Requests from voters that have already voted are ignored; gnt stays 0 for them. gnt is 0 in every state other than COLLECT.
- COLLECT exits to DECIDE when voted_mask becomes all-ones or when close is high. If close and a grant occur in the same cycle, the ballot is counted first, then the round closes.
- DECIDE (1 cycle): result = (yes_cnt > no_cnt) | ((yes_cnt == no_cnt) & tie_break), then go to DONE. A round with zero ballots therefore yields tie_break.
- DONE: result, result_valid and the counts hold until the next start.
- Counts never exceed NUM_VOTERS, so CNT_W never overflows.

## Timing
- A ballot is accepted on the same edge as its grant; voted_mask and the counts update on that edge.
- Last ballot accepted at edge N: DECIDE during cycle N→N+1, result_valid = 1 after edge N+1.
- close sampled at edge N: identical timing to the last-ballot case.
- start in COLLECT or DECIDE is ignored. close outside COLLECT is ignored.
- Asserting rst_n low mid-round immediately returns the block to the reset values; the partial round is discarded.

## Configuration
- VOTE_TIMEOUT_EN defined: a cycle counter clears on entry to COLLECT and increments each COLLECT cycle. When it reaches TIMEOUT_CYC-1, the block treats that cycle as close and sets timed_out, which holds through DONE.
- VOTE_TIMEOUT_EN undefined: no counter; a round only ends by full participation or close; timed_out is tied 0.

## Test plan
- Reset, start; all 7 voters request together with ballots 1,1,0,1,0,0,1 → grants in order 0..6 on consecutive cycles, yes_cnt=4, no_cnt=3, result=1, result_valid 2 cycles after the last grant.
- Pointer at 5 with requests from voters 2 and 6 → voter 6 granted first, then voter 2; a re-request from voter 6 is never granted.
- 3 yes, 3 no, then close; tie_break=0 → result 0. Repeat with tie_break=1 → result 1.
- close in the same cycle as a yes grant → that ballot is counted, and the round closes with updated counts.
- rst_n low after 3 ballots → all outputs 0 and state IDLE; a following start and 7 no-ballots → result 0.
- VOTE_TIMEOUT_EN, TIMEOUT_CYC=8, only 2 yes ballots → round closes after 8 COLLECT cycles, timed_out=1, result=1.
